alu_seq_muldiv: RTL and testbench

//   Multi-cycle multiply/divide responder for the 16-bit datapath.
//   - Accepts operands A/B plus a CTRL opcode on a start/busy/done handshake.
//   - Runs an iterative shift-add multiply or a restoring divide.
//   - Returns result/overflow words with the same meaning as the combinational ALU:

---
 rtl/alu_seq_muldiv.sv | 150 +++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit with a
// start/busy/done handshake; overflow carries the high product word or the remainder.
module alu_seq_muldiv #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       CTRL,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] overflow,
   output logic             div_by_zero,
   output logic             illegal_op
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] overflow_q, overflow_d;
   logic             dbz_q, dbz_d;
   logic             ill_q, ill_d;

   logic             lastIter;
   logic [WIDTH:0]   mulSum;
   logic [WIDTH:0]   mulPre;
   logic [2*WIDTH-1:0] mulNext;
   logic [WIDTH:0]   remShift;
   logic [WIDTH-1:0] remDiff;
   logic             borrow;
   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] quotNext;

   assign lastIter = (cnt_q == 5'(WIDTH - 1));

   // hi holds the upper accumulator / remainder, lo the multiplier / quotient
   assign mulSum   = {1'b0, hi_q} + {1'b0, opnd_q};
   assign mulPre   = lo_q[0] ? mulSum : {1'b0, hi_q};
   assign mulNext  = {mulPre, lo_q[WIDTH-1:1]};

   // The true difference is below the divisor when kept, so WIDTH bits suffice
   assign remShift = {hi_q, lo_q[WIDTH-1]};
   assign borrow   = (remShift < {1'b0, opnd_q});
   assign remDiff  = remShift[WIDTH-1:0] - opnd_q;
   assign remNext  = borrow ? remShift[WIDTH-1:0] : remDiff;
   assign quotNext = {lo_q[WIDTH-2:0], ~borrow};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      opnd_d     = opnd_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      dbz_d      = dbz_q;
      ill_d      = ill_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d = '0;
               dbz_d = 1'b0;
               ill_d = 1'b0;
               if (CTRL == 3'b100) begin
                  opnd_d  = A;
                  hi_d    = '0;
                  lo_d    = B;
                  state_d = MUL;
               end else if (CTRL == 3'b101 && B != '0) begin
                  opnd_d  = B;
                  hi_d    = '0;
                  lo_d    = A;
                  state_d = DIV;
               end else if (CTRL == 3'b101) begin
                  result_d   = '1;
                  overflow_d = A;
                  dbz_d      = 1'b1;
                  state_d    = DONE;
               end else begin
                  result_d   = '0;
                  overflow_d = '0;
                  ill_d      = 1'b1;
                  state_d    = DONE;
               end
            end
         end
         MUL: begin
            {hi_d, lo_d} = mulNext;
            cnt_d        = cnt_q + 5'd1;
            if (lastIter) begin
               result_d   = mulNext[WIDTH-1:0];
               overflow_d = mulNext[2*WIDTH-1:WIDTH];
               state_d    = DONE;
            end
         end
         DIV: begin
            hi_d  = remNext;
            lo_d  = quotNext;
            cnt_d = cnt_q + 5'd1;
            if (lastIter) begin
               result_d   = quotNext;
               overflow_d = remNext;
               state_d    = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         opnd_q     <= '0;
         result_q   <= '0;
         overflow_q <= '0;
         dbz_q      <= 1'b0;
         ill_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         opnd_q     <= opnd_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         dbz_q      <= dbz_d;
         ill_q      <= ill_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign result      = result_q;
   assign overflow    = overflow_q;
   assign div_by_zero = dbz_q;
   assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Bench for alu_seq_muldiv: directed vector table, randomized operations against
// an arithmetic reference model, busy-time start poking and mid-operation reset.
module tb_alu_seq_muldiv;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [2:0]    CTRL;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic [W-1:0]  overflow;
   logic          div_by_zero;
   logic          illegal_op;

   int checks   = 0;
   int failures = 0;

   alu_seq_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .CTRL(CTRL),
      .busy(busy), .done(done), .result(result), .overflow(overflow),
      .div_by_zero(div_by_zero), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   ctrl;
      logic [W-1:0] res;
      logic [W-1:0] ovf;
      logic         dbz;
      logic         ill;
      int           lat;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: plain unsigned arithmetic on the opcode rules
   task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ctrl,
                           output vec_t v);
      logic [2*W-1:0] prod;
      v.a = a; v.b = b; v.ctrl = ctrl;
      v.dbz = 1'b0; v.ill = 1'b0;
      if (ctrl == 3'b100) begin
         prod  = (2*W)'(a) * (2*W)'(b);
         v.res = prod[W-1:0];
         v.ovf = prod[2*W-1:W];
         v.lat = W + 1;
      end else if (ctrl == 3'b101 && b != 0) begin
         v.res = a / b;
         v.ovf = a % b;
         v.lat = W + 1;
      end else if (ctrl == 3'b101) begin
         v.res = '1; v.ovf = a; v.dbz = 1'b1; v.lat = 1;
      end else begin
         v.res = '0; v.ovf = '0; v.ill = 1'b1; v.lat = 1;
      end
   endtask

   // Called about 1ns after a rising edge while the DUT is idle; returns in the cycle done is seen
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] ctrl,
                                input int pokeCycle, output int lat,
                                output logic [W-1:0] res, output logic [W-1:0] ovf,
                                output logic dbz, output logic ill);
      A = a; B = b; CTRL = ctrl; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; res = 'x; ovf = 'x; dbz = 1'bx; ill = 1'bx;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc == 1) checkOutput("busy_cycle1", busy, 1);
         if (cyc == pokeCycle) begin
            start = 1'b1; A = ~a; B = a ^ b ^ 16'h1234; CTRL = 3'b101;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            lat = cyc; res = result; ovf = overflow; dbz = div_by_zero; ill = illegal_op;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic verifyOp(input vec_t v, input int pokeCycle);
      int lat;
      logic [W-1:0] res, ovf;
      logic dbz, ill;
      applyStimulus(v.a, v.b, v.ctrl, pokeCycle, lat, res, ovf, dbz, ill);
      checkOutput("latency", lat, v.lat);
      checkOutput("result", res, v.res);
      checkOutput("overflow", ovf, v.ovf);
      checkOutput("div_by_zero", dbz, v.dbz);
      checkOutput("illegal_op", ill, v.ill);
      @(posedge clk); #1;
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
      checkOutput("hold_result", result, v.res);
      checkOutput("hold_overflow", overflow, v.ovf);
   endtask

   initial begin
      vec_t v;
      logic [2:0] c;
      logic [W-1:0] ra, rb;
      int sawDone;

      vecs[0] = '{16'h7676, 16'h4321, 3'b100, 16'h2736, 16'h1F10, 1'b0, 1'b0, 17};
      vecs[1] = '{16'hFFFF, 16'hB0B0, 3'b101, 16'h0001, 16'h4F4F, 1'b0, 1'b0, 17};
      vecs[2] = '{16'hFFFF, 16'hFFFF, 3'b100, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 17};
      vecs[3] = '{16'h0002, 16'h0000, 3'b101, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 1};
      vecs[4] = '{16'h1234, 16'h5678, 3'b110, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
      vecs[5] = '{16'h0000, 16'hFFFF, 3'b100, 16'h0000, 16'h0000, 1'b0, 1'b0, 17};
      vecs[6] = '{16'h0005, 16'h0007, 3'b101, 16'h0000, 16'h0005, 1'b0, 1'b0, 17};

      rst_n = 1'b0; start = 1'b0; A = '0; B = '0; CTRL = '0;
      #12;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_result", result, 0);
      checkOutput("reset_overflow", overflow, 0);
      checkOutput("reset_flags", {div_by_zero, illegal_op}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors, issued back-to-back from the first idle cycle
      for (int i = 0; i < 7; i++) verifyOp(vecs[i], 0);

      // Start poked with new operands while busy must not disturb the operation
      verifyOp(vecs[0], 5);
      verifyOp(vecs[3], 1);

      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
         case ($urandom_range(0, 5))
            0, 1, 2: c = 3'b100;
            3, 4:    c = 3'b101;
            default: c = 3'($urandom);
         endcase
         refModel(ra, rb, c, v);
         verifyOp(v, (i % 3 == 0) ? 3 + i % 10 : 0);
      end

      // Mid-operation reset: outputs clear asynchronously and no done follows
      A = 16'h7676; B = 16'h4321; CTRL = 3'b100; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (7) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_result", result, 0);
      checkOutput("abort_overflow", overflow, 0);
      @(negedge clk); rst_n = 1'b1;
      sawDone = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done || busy) sawDone = 1;
      end
      checkOutput("abort_no_done", sawDone, 0);
      refModel(16'h6234, 16'h0007, 3'b101, v);
      verifyOp(v, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
